// File: rtl/lc3_mem_arbiter.sv
// Round-robin two-master arbiter for the single LC3 memory port (EN/WE/RDY handshake).
// Optional transaction watchdog with arb_err output: define LC3_ARB_WATCHDOG_EN.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_en,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_din,
  output logic [DATA_W-1:0] m0_dout,
  output logic              m0_rdy,
  input  logic              m1_en,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_din,
  output logic [DATA_W-1:0] m1_dout,
  output logic              m1_rdy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_rdy
`ifdef LC3_ARB_WATCHDOG_EN
  ,
  output logic              arb_err
`endif
);

  localparam int unsigned CNT_W = 10;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..1023");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY0, ST_BUSY1} state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                grant0_c, grant1_c;
  logic                timeout_c, done_c;
  logic [DATA_W-1:0]   rsp_data_c;
`ifdef LC3_ARB_WATCHDOG_EN
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Tie goes to the master that was not served last.
  assign grant0_c = m0_en && (!m1_en || last_q);
  assign grant1_c = m1_en && !grant0_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
`ifdef LC3_ARB_WATCHDOG_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
`ifdef LC3_ARB_WATCHDOG_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    mem_en_d   = mem_en_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    m0_rdy     = 1'b0;
    m1_rdy     = 1'b0;
    m0_dout    = '0;
    m1_dout    = '0;
    timeout_c  = 1'b0;
    rsp_data_c = mem_dout;
`ifdef LC3_ARB_WATCHDOG_EN
    cnt_d      = cnt_q;
    arb_err    = 1'b0;
    // A real mem_rdy in the expiry cycle wins over the abort.
    timeout_c  = (state_q != ST_IDLE) && !mem_rdy && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif
    done_c = (state_q != ST_IDLE) && (mem_rdy || timeout_c);

    case (state_q)
      ST_IDLE: begin
        if (grant0_c) begin
          state_d    = ST_BUSY0;
          mem_en_d   = 1'b1;
          mem_we_d   = m0_we;
          mem_addr_d = m0_addr;
          mem_din_d  = m0_din;
        end else if (grant1_c) begin
          state_d    = ST_BUSY1;
          mem_en_d   = 1'b1;
          mem_we_d   = m1_we;
          mem_addr_d = m1_addr;
          mem_din_d  = m1_din;
        end
`ifdef LC3_ARB_WATCHDOG_EN
        cnt_d = '0;
`endif
      end
      default: begin
`ifdef LC3_ARB_WATCHDOG_EN
        if (!done_c) cnt_d = cnt_q + CNT_W'(1);
`endif
      end
    endcase

    // Completion (normal or aborted) returns to IDLE, forcing one idle cycle.
    if (done_c) begin
      state_d    = ST_IDLE;
      last_d     = (state_q == ST_BUSY1);
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = '0;
      mem_din_d  = '0;
      if (timeout_c) rsp_data_c = DATA_W'(16'hDEAD);
      if (state_q == ST_BUSY0) begin
        m0_rdy  = 1'b1;
        m0_dout = rsp_data_c;
      end else begin
        m1_rdy  = 1'b1;
        m1_dout = rsp_data_c;
      end
`ifdef LC3_ARB_WATCHDOG_EN
      arb_err = timeout_c;
`endif
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Table-driven bench for lc3_mem_arbiter; watchdog sequence included when LC3_ARB_WATCHDOG_EN is defined.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_en, m0_we, m1_en, m1_we;
  logic [15:0] m0_addr, m0_din, m1_addr, m1_din;
  logic [15:0] m0_dout, m1_dout;
  logic        m0_rdy, m1_rdy;
  logic        mem_en, mem_we, mem_rdy;
  logic [15:0] mem_addr, mem_din, mem_dout;
`ifdef LC3_ARB_WATCHDOG_EN
  logic        arb_err;
`endif

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_en(m0_en), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_dout(m0_dout), .m0_rdy(m0_rdy),
    .m1_en(m1_en), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_dout(m1_dout), .m1_rdy(m1_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_rdy(mem_rdy)
`ifdef LC3_ARB_WATCHDOG_EN
    , .arb_err(arb_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [15:0] din;
    logic        r0;
    logic [15:0] d0;
    logic        r1;
    logic [15:0] d1;
  } out_t;

  typedef struct {
    logic        rst;
    logic        m0_en, m0_we;
    logic [15:0] m0_addr, m0_din;
    logic        m1_en, m1_we;
    logic [15:0] m1_addr, m1_din;
    logic [15:0] mem_dout;
    logic        mem_rdy;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic void add(input logic r,
      input logic a_en, input logic a_we, input logic [15:0] a_addr, input logic [15:0] a_din,
      input logic b_en, input logic b_we, input logic [15:0] b_addr, input logic [15:0] b_din,
      input logic [15:0] md, input logic mr,
      input logic e_en, input logic e_we, input logic [15:0] e_addr, input logic [15:0] e_din,
      input logic e_r0, input logic [15:0] e_d0, input logic e_r1, input logic [15:0] e_d1);
    vec_t v;
    v.rst = r;
    v.m0_en = a_en; v.m0_we = a_we; v.m0_addr = a_addr; v.m0_din = a_din;
    v.m1_en = b_en; v.m1_we = b_we; v.m1_addr = b_addr; v.m1_din = b_din;
    v.mem_dout = md; v.mem_rdy = mr;
    v.exp = '{e_en, e_we, e_addr, e_din, e_r0, e_d0, e_r1, e_d1};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    m0_en = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_din = '0;
    m1_en = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_din = '0;
    mem_dout = '0; mem_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    out_t got;
    int   n;

    // rst, m0{en,we,addr,din}, m1{en,we,addr,din}, mem_dout, mem_rdy | exp mem{en,we,addr,din}, m0{rdy,dout}, m1{rdy,dout}
    // m0 read 3000, data after 3 busy cycles
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 1,0,16'h3000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 1,0,16'h3000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234,1, 1,0,16'h3000,16'h0000, 1,16'h1234, 0,16'h0000);
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h5555,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    // stray mem_rdy while idle
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'hABCD,1, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    // m1 write BEEF -> 0200, master changes inputs mid-transaction
    add(0, 0,0,16'h0000,16'h0000, 1,1,16'h0200,16'hBEEF, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 0,0,16'h0000,16'h0000, 1,1,16'h0200,16'hBEEF, 16'h0000,0, 1,1,16'h0200,16'hBEEF, 0,16'h0000, 0,16'h0000);
    add(0, 0,0,16'h0000,16'h0000, 1,1,16'h0FFF,16'h1111, 16'h0000,0, 1,1,16'h0200,16'hBEEF, 0,16'h0000, 0,16'h0000);
    add(0, 0,0,16'h0000,16'h0000, 1,1,16'h0FFF,16'h1111, 16'h7777,1, 1,1,16'h0200,16'hBEEF, 0,16'h0000, 1,16'h7777);
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    // repeated ties alternate m0, m1, m0, m1
    add(0, 1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 16'h0000,0, 1,0,16'h0010,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 16'h0A0A,1, 1,0,16'h0010,16'h0000, 1,16'h0A0A, 0,16'h0000);
    add(0, 1,0,16'h0011,16'h0000, 1,0,16'h0020,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h0011,16'h0000, 1,0,16'h0020,16'h0000, 16'h0B0B,1, 1,0,16'h0020,16'h0000, 0,16'h0000, 1,16'h0B0B);
    add(0, 1,0,16'h0011,16'h0000, 1,0,16'h0021,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h0011,16'h0000, 1,0,16'h0021,16'h0000, 16'h0C0C,1, 1,0,16'h0011,16'h0000, 1,16'h0C0C, 0,16'h0000);
    add(0, 1,0,16'h0012,16'h0000, 1,0,16'h0021,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h0012,16'h0000, 1,0,16'h0021,16'h0000, 16'h0D0D,1, 1,0,16'h0021,16'h0000, 0,16'h0000, 1,16'h0D0D);
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    // m0 drops en right after the grant: transaction still completes
    add(0, 1,1,16'h0040,16'h4444, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 0,1,16'h0040,16'h4444, 0,0,16'h0000,16'h0000, 16'h0000,0, 1,1,16'h0040,16'h4444, 0,16'h0000, 0,16'h0000);
    add(0, 0,1,16'h0040,16'h4444, 0,0,16'h0000,16'h0000, 16'h9999,1, 1,1,16'h0040,16'h4444, 1,16'h9999, 0,16'h0000);
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    // reset two cycles into an m0 transaction (last grant was m0)
    add(0, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 1,0,16'h3000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(1, 1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 1,0,16'h3000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234,1, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h0050,16'h0000, 1,0,16'h0060,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0, 1,0,16'h0050,16'h0000, 1,0,16'h0060,16'h0000, 16'h2222,1, 1,0,16'h0050,16'h0000, 1,16'h2222, 0,16'h0000);
    add(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000,0, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      m0_en = vecs[i].m0_en; m0_we = vecs[i].m0_we; m0_addr = vecs[i].m0_addr; m0_din = vecs[i].m0_din;
      m1_en = vecs[i].m1_en; m1_we = vecs[i].m1_we; m1_addr = vecs[i].m1_addr; m1_din = vecs[i].m1_din;
      mem_dout = vecs[i].mem_dout; mem_rdy = vecs[i].mem_rdy;
      #1;
      got = '{mem_en, mem_we, mem_addr, mem_din, m0_rdy, m0_dout, m1_rdy, m1_dout};
      applied++;
      if (got !== vecs[i].exp) begin
        miscompares++;
        $display("FAIL vec%0d: got en=%b we=%b addr=%h din=%h r0=%b d0=%h r1=%b d1=%h, required en=%b we=%b addr=%h din=%h r0=%b d0=%h r1=%b d1=%h",
                 i, got.en, got.we, got.addr, got.din, got.r0, got.d0, got.r1, got.d1,
                 vecs[i].exp.en, vecs[i].exp.we, vecs[i].exp.addr, vecs[i].exp.din,
                 vecs[i].exp.r0, vecs[i].exp.d0, vecs[i].exp.r1, vecs[i].exp.d1);
      end
    end

    // Lone m1 request: grant latency measured with a bounded wait
    @(negedge clk);
    idle_inputs();
    m1_en = 1'b1; m1_addr = 16'h0123;
    #1;
    n = 0;
    while (!mem_en && n < 5) begin
      @(negedge clk); #1;
      n++;
    end
    chk("m1_grant_latency", 32'(n), 32'd1);
    chk("m1_grant_addr", 32'(mem_addr), 32'h0123);
    @(negedge clk);
    mem_dout = 16'h5A5A; mem_rdy = 1'b1;
    #1;
    chk("m1_done", {15'd0, m1_rdy, m1_dout}, {15'd0, 1'b1, 16'h5A5A});
    chk("m1_done_m0_quiet", {15'd0, m0_rdy, m0_dout}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("m1_release", {30'd0, mem_en, m1_rdy}, 32'd0);

`ifdef LC3_ARB_WATCHDOG_EN
    // m0 read never answered: abort after 8 busy cycles
    @(negedge clk);
    m0_en = 1'b1; m0_addr = 16'h3000;
    #1;
    chk("wd_pre_grant", {29'd0, mem_en, m0_rdy, arb_err}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk("wd_busy", {29'd0, mem_en, m0_rdy, arb_err}, 32'b100);
    end
    @(negedge clk); #1;
    chk("wd_abort", {29'd0, mem_en, m0_rdy, arb_err}, 32'b111);
    chk("wd_abort_dout", 32'(m0_dout), 32'hDEAD);
    @(negedge clk);
    m0_en = 1'b0;
    #1;
    chk("wd_after", {29'd0, mem_en, m0_rdy, arb_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
